// File: rtl/cdn_reset_pkg.sv
// cdn_reset_pkg: shared states, default channel indices and the lowest-set-bit helper
// used by the reset sequencer.
package cdn_reset_pkg;

    localparam int MAX_CH  = 16;
    localparam int CH_PHY  = 0;
    localparam int CH_APB  = 1;
    localparam int CH_UC   = 2;
    localparam int CH_JTAG = 3;

    typedef enum logic [2:0] {
        ST_POR_HOLD,
        ST_ASSERT,
        ST_HOLD,
        ST_REL,
        ST_GAP,
        ST_DONE,
        ST_IDLE
    } state_e;

    // Returns a one-hot vector of the lowest set bit; zero in gives zero out.
    function automatic logic [MAX_CH-1:0] lowest_set(input logic [MAX_CH-1:0] v);
        return v & (-v);
    endfunction

endpackage

// File: rtl/cdn_reset_sync.sv
// cdn_reset_sync: asynchronous-assert, synchronous-deassert reset synchroniser.
module cdn_reset_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_sync <= '0;
        else
            r_sync <= {r_sync[STAGES-2:0], 1'b1};
    end

    assign o_rst_n = r_sync[STAGES-1];

endmodule

// File: rtl/cdn_reset_seq.sv
// cdn_reset_seq: ordered power-on release and masked run-time reset requests with
// programmable hold and staggered lowest-index-first release of NUM_CH domain resets.
module cdn_reset_seq
    import cdn_reset_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int POR_HOLD    = 16,
    parameter int GAP_CYC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [NUM_CH-1:0] req_mask,
    input  logic [CNT_W-1:0]  req_hold,
    output logic [NUM_CH-1:0] rst_out,
    output logic              busy,
    output logic              done
);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("cdn_reset_seq: NUM_CH must be 1..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("cdn_reset_seq: SYNC_STAGES must be >= 2");
    end
    if (POR_HOLD >= (1 << CNT_W) || GAP_CYC >= (1 << CNT_W)) begin : g_bad_cnt
        $error("cdn_reset_seq: POR_HOLD and GAP_CYC must fit in CNT_W bits");
    end

    // The counter is loaded with N-1 on entry so the Nth cycle in a state is the exit cycle.
    localparam logic [CNT_W-1:0] POR_LD = CNT_W'(POR_HOLD > 0 ? POR_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);

    logic              w_rst_n;
    logic [NUM_CH-1:0] w_rel;
    logic [CNT_W-1:0]  w_hold_ld;
    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_rst;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;

    cdn_reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .o_rst_n (w_rst_n)
    );

    assign w_rel     = NUM_CH'(lowest_set(MAX_CH'(r_pend)));
    assign w_hold_ld = (req_hold == '0) ? '0 : req_hold - 1'b1;

    // Releases take effect on the edge entering REL, so REL is the first cycle the bit reads low.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_POR_HOLD;
            r_cnt   <= POR_LD;
            r_pend  <= '1;
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_rst   <= r_rst | req_mask;
                    r_pend  <= req_mask;
                    r_cnt   <= w_hold_ld;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                    r_done  <= ~|req_mask;
                    r_state <= |req_mask ? ST_ASSERT : ST_DONE;
                end
                ST_ASSERT: r_state <= ST_HOLD;
                ST_POR_HOLD, ST_HOLD, ST_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rst   <= r_rst & ~w_rel;
                        r_pend  <= r_pend & ~w_rel;
                        r_state <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (r_pend == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (GAP_CYC != 0) begin
                        r_cnt   <= GAP_LD;
                        r_state <= ST_GAP;
                    end else begin
                        r_rst  <= r_rst & ~w_rel;
                        r_pend <= r_pend & ~w_rel;
                    end
                end
                ST_DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_DONE;
            endcase
        end
    end

    assign rst_out   = r_rst;
    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
